// File: rtl/uart_alu_pkg.sv
// ----------------------------------------------------------------------------
// uart_alu_pkg : shared type codes, ALU funct codes, FSM state types
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_alu_pkg;

   localparam int DATA_W = 8;

   localparam logic [7:0] TYPE_A  = 8'h08;
   localparam logic [7:0] TYPE_B  = 8'h10;
   localparam logic [7:0] TYPE_OP = 8'h20;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_SRL = 6'h02;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   typedef enum logic {
      W_TYPE  = 1'b0,
      W_VALUE = 1'b1
   } if_state_t;

   typedef enum logic [1:0] {
      K_A  = 2'd0,
      K_B  = 2'd1,
      K_OP = 2'd2
   } load_kind_t;

   // Rounded clocks-per-tick divider.
   function automatic int baud_div(input int clk_freq, input int baud, input int os);
      return (clk_freq + (baud * os) / 2) / (baud * os);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu : combinational ALU on MIPS funct codes, results wrap, unknown -> 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu
   import uart_alu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [5:0]        op,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         FN_ADD:  y = a + b;
         FN_SUB:  y = a - b;
         FN_AND:  y = a & b;
         FN_OR:   y = a | b;
         FN_XOR:  y = a ^ b;
         FN_NOR:  y = ~(a | b);
         FN_SRA:  y = $signed(a) >>> b;
         FN_SRL:  y = a >> b;
         default: y = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/baud_gen.sv
// ----------------------------------------------------------------------------
// baud_gen : free-running divider, one-clk tick every DIV clocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module baud_gen #(
   parameter int DIV = 326
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 receiver, 2-flop synchronizer, mid-bit sampling on baud ticks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
   import uart_alu_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int OVERSAMPLING = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              rx,
   output logic              done,
   output logic [DATA_W-1:0] data
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLING / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLING - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

   logic              rx_meta, rx_sync;
   uart_state_t       state, state_nx;
   logic [TW-1:0]     tcnt, tcnt_nx;
   logic [BW-1:0]     bcnt, bcnt_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic              done_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         state   <= S_IDLE;
         tcnt    <= '0;
         bcnt    <= '0;
         shreg   <= '0;
         done    <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         state   <= state_nx;
         tcnt    <= tcnt_nx;
         bcnt    <= bcnt_nx;
         shreg   <= shreg_nx;
         done    <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      tcnt_nx  = tcnt;
      bcnt_nx  = bcnt;
      shreg_nx = shreg;
      done_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!rx_sync) begin
               tcnt_nx  = '0;
               state_nx = S_START;
            end
         end
         S_START: begin
            // Half-bit recheck rejects short low glitches.
            if (tick) begin
               if (tcnt == HALF_TICK) begin
                  tcnt_nx  = '0;
                  bcnt_nx  = '0;
                  state_nx = rx_sync ? S_IDLE : S_DATA;
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tcnt == LAST_TICK) begin
                  tcnt_nx  = '0;
                  shreg_nx = {rx_sync, shreg[DATA_W-1:1]};
                  if (bcnt == LAST_BIT) begin
                     state_nx = S_STOP;
                  end else begin
                     bcnt_nx = bcnt + BW'(1);
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tcnt == LAST_TICK) begin
                  tcnt_nx  = '0;
                  done_nx  = rx_sync;
                  state_nx = S_IDLE;
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign data = shreg;

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ----------------------------------------------------------------------------
// uart_tx : 8N1 transmitter, 16 ticks per bit, registered line output
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx
   import uart_alu_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int OVERSAMPLING = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              start,
   input  logic [DATA_W-1:0] din,
   output logic              tx,
   output logic              done
);

   localparam int TW = $clog2(OVERSAMPLING);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLING - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

   uart_state_t       state, state_nx;
   logic [TW-1:0]     tcnt, tcnt_nx;
   logic [BW-1:0]     bcnt, bcnt_nx;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic              tx_nx, done_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         tcnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
         tx    <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         tcnt  <= tcnt_nx;
         bcnt  <= bcnt_nx;
         shreg <= shreg_nx;
         tx    <= tx_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      tcnt_nx  = tcnt;
      bcnt_nx  = bcnt;
      shreg_nx = shreg;
      done_nx  = 1'b0;
      tx_nx    = 1'b1;
      case (state)
         S_IDLE: begin
            if (start) begin
               shreg_nx = din;
               tcnt_nx  = '0;
               bcnt_nx  = '0;
               state_nx = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (tcnt == LAST_TICK) begin
                  tcnt_nx  = '0;
                  state_nx = S_DATA;
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tcnt == LAST_TICK) begin
                  tcnt_nx  = '0;
                  shreg_nx = shreg >> 1;
                  if (bcnt == LAST_BIT) begin
                     state_nx = S_STOP;
                  end else begin
                     bcnt_nx = bcnt + BW'(1);
                  end
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tcnt == LAST_TICK) begin
                  tcnt_nx  = '0;
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  tcnt_nx = tcnt + TW'(1);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // Line level follows the state being entered so it is glitch-free.
      case (state_nx)
         S_START: tx_nx = 1'b0;
         S_DATA:  tx_nx = shreg_nx[0];
         default: tx_nx = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/uart_alu_top.sv
// ----------------------------------------------------------------------------
// uart_alu_top : serial-controlled ALU, (type,value) byte pairs in, result out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_alu_top
   import uart_alu_pkg::*;
#(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD_RATE    = 19200,
   parameter int OVERSAMPLING = 16,
   parameter int DATA_W       = 8
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_rx,
   output logic o_tx
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLING);

   logic              tick;
   logic              rx_done;
   logic [DATA_W-1:0] rx_data;
   logic              tx_start, tx_go, tx_busy, tx_done;
   logic [DATA_W-1:0] operand_a, operand_b, result;
   logic [5:0]        opcode;
   if_state_t         if_state, if_state_nx;
   load_kind_t        kind, kind_nx;

   baud_gen #(
      .DIV (BAUD_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (i_rst_n),
      .tick  (tick)
   );

   uart_rx #(
      .DATA_W       (DATA_W),
      .OVERSAMPLING (OVERSAMPLING)
   ) u_rx (
      .clk   (clk),
      .rst_n (i_rst_n),
      .tick  (tick),
      .rx    (i_rx),
      .done  (rx_done),
      .data  (rx_data)
   );

   alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a  (operand_a),
      .b  (operand_b),
      .op (opcode),
      .y  (result)
   );

   // Requests arriving while a frame is in flight are dropped.
   assign tx_go = tx_start & ~tx_busy;

   uart_tx #(
      .DATA_W       (DATA_W),
      .OVERSAMPLING (OVERSAMPLING)
   ) u_tx (
      .clk   (clk),
      .rst_n (i_rst_n),
      .tick  (tick),
      .start (tx_go),
      .din   (result),
      .tx    (o_tx),
      .done  (tx_done)
   );

   always_comb begin
      if_state_nx = if_state;
      kind_nx     = kind;
      case (if_state)
         W_TYPE: begin
            if (rx_done) begin
               if (rx_data == TYPE_A) begin
                  kind_nx     = K_A;
                  if_state_nx = W_VALUE;
               end else if (rx_data == TYPE_B) begin
                  kind_nx     = K_B;
                  if_state_nx = W_VALUE;
               end else if (rx_data == TYPE_OP) begin
                  kind_nx     = K_OP;
                  if_state_nx = W_VALUE;
               end
            end
         end
         W_VALUE: begin
            if (rx_done) begin
               if_state_nx = W_TYPE;
            end
         end
         default: if_state_nx = W_TYPE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         if_state  <= W_TYPE;
         kind      <= K_A;
         operand_a <= '0;
         operand_b <= '0;
         opcode    <= '0;
         tx_start  <= 1'b0;
         tx_busy   <= 1'b0;
      end else begin
         if_state <= if_state_nx;
         kind     <= kind_nx;
         // Delayed one clk so the ALU already sees the new opcode.
         tx_start <= 1'b0;
         if (if_state == W_VALUE && rx_done) begin
            case (kind)
               K_A:  operand_a <= rx_data;
               K_B:  operand_b <= rx_data;
               K_OP: begin
                  opcode   <= rx_data[5:0];
                  tx_start <= 1'b1;
               end
               default: ;
            endcase
         end
         if (tx_go) begin
            tx_busy <= 1'b1;
         end else if (tx_done) begin
            tx_busy <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_alu_top.sv
// ----------------------------------------------------------------------------
// tb_uart_alu_top : byte-stream reference model, TX frame decoder/scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_alu_top;

   localparam int CLK_FREQ = 48_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int OS       = 16;
   localparam int DIV      = (CLK_FREQ + (BAUD * OS) / 2) / (BAUD * OS);
   localparam int BIT      = DIV * OS;

   logic clk     = 1'b0;
   logic i_rst_n = 1'b0;
   logic i_rx    = 1'b1;
   logic o_tx;

   int vectors     = 0;
   int miscompares = 0;
   int rst_cnt     = 0;

   logic [7:0] exp_q[$];
   bit         m_wait_value;
   logic [7:0] m_kind, m_a, m_b, last_res;
   logic [5:0] m_op;
   logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

   uart_alu_top #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD_RATE    (BAUD),
      .OVERSAMPLING (OS),
      .DATA_W       (8)
   ) dut (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_rx    (i_rx),
      .o_tx    (o_tx)
   );

   always #5 clk = ~clk;

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, req);
      end
   endtask

   function automatic logic [7:0] alu_ref(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
      int s;
      s = a[7] ? int'(a) - 256 : int'(a);
      case (op)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         6'h03: return (b >= 8) ? (a[7] ? 8'hFF : 8'h00) : 8'(s >>> b);
         6'h02: return (b >= 8) ? 8'h00 : 8'(int'(a) / (1 << b));
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_wait_value = 1'b0;
      m_kind = 8'h00;
      m_a = 8'h00;
      m_b = 8'h00;
      m_op = 6'h00;
   endtask

   // Reference view of the byte stream: a (type, value) pair at a time.
   task automatic model_byte(input logic [7:0] v);
      if (!m_wait_value) begin
         if (v == 8'h08 || v == 8'h10 || v == 8'h20) begin
            m_kind = v;
            m_wait_value = 1'b1;
         end
      end else begin
         m_wait_value = 1'b0;
         if (m_kind == 8'h08) m_a = v;
         else if (m_kind == 8'h10) m_b = v;
         else begin
            m_op = v[5:0];
            last_res = alu_ref(m_op, m_a, m_b);
            exp_q.push_back(last_res);
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] v, input bit good_stop);
      i_rx = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 8; i++) begin
         i_rx = v[i];
         wait_clks(BIT);
      end
      if (good_stop) begin
         i_rx = 1'b1;
         wait_clks(BIT);
      end else begin
         i_rx = 1'b0;
         wait_clks(BIT * 3 / 4);
         i_rx = 1'b1;
         wait_clks(BIT - BIT * 3 / 4);
      end
      wait_clks(BIT);
   endtask

   task automatic send_byte(input logic [7:0] v);
      send_frame(v, 1'b1);
      model_byte(v);
   endtask

   task automatic send_pair(input logic [7:0] t, input logic [7:0] v);
      send_byte(t);
      send_byte(v);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      rst_cnt++;
      exp_q.delete();
      model_reset();
      wait_clks(1);
      check("tx_high_in_reset", {7'b0, o_tx}, 8'h01);
      wait_clks(1);
      i_rst_n = 1'b1;
   endtask

   // Decodes every frame on o_tx and scores it against the model queue.
   initial begin : monitor
      logic [7:0] got;
      logic       sb, pb;
      int         rc;
      forever begin
         @(negedge clk);
         if (i_rst_n === 1'b1 && o_tx === 1'b0) begin
            rc = rst_cnt;
            wait_clks(BIT / 2);
            sb = o_tx;
            for (int i = 0; i < 8; i++) begin
               wait_clks(BIT);
               got[i] = o_tx;
            end
            wait_clks(BIT);
            pb = o_tx;
            if (rc == rst_cnt) begin
               check("tx_start_bit", {7'b0, sb}, 8'h00);
               check("tx_stop_bit", {7'b0, pb}, 8'h01);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL tx_unexpected_frame: got 0x%02h, required no frame", got);
               end else begin
                  check("tx_result", got, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin : watchdog
      #(90_000 * 10);
      $display("FAIL watchdog: run still active at cycle limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bit         bad;
      int         guard;
      logic [7:0] t, v;

      model_reset();
      last_res = 8'h00;
      do_reset();
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wait_clks(1);
         if (o_tx !== 1'b1) bad = 1'b1;
      end
      check("tx_idle_after_reset", {7'b0, bad}, 8'h00);

      send_pair(8'h08, 8'h01);
      send_pair(8'h10, 8'h08);
      send_pair(8'h20, 8'h20);
      check("pin_add", last_res, 8'h09);
      send_pair(8'h10, 8'hFF);
      send_pair(8'h20, 8'h20);
      check("pin_add_wrap", last_res, 8'h00);
      send_pair(8'h20, 8'h22);
      check("pin_sub", last_res, 8'h02);
      send_pair(8'h20, 8'h24);
      check("pin_and", last_res, 8'h01);

      send_pair(8'h08, 8'h80);
      send_pair(8'h10, 8'h02);
      send_pair(8'h20, 8'h03);
      check("pin_sra", last_res, 8'hE0);
      send_pair(8'h20, 8'h02);
      check("pin_srl", last_res, 8'h20);
      send_pair(8'h20, 8'h3F);
      check("pin_unknown_op", last_res, 8'h00);

      send_pair(8'h10, 8'h01);
      send_byte(8'h55);
      send_pair(8'h08, 8'h07);
      send_pair(8'h20, 8'h20);
      check("pin_unknown_type", last_res, 8'h08);

      // Glitch while awaiting A's value; bad-stop frame while awaiting B's.
      send_byte(8'h08);
      i_rx = 1'b0;
      wait_clks(DIV);
      i_rx = 1'b1;
      wait_clks(2 * BIT);
      send_byte(8'h44);
      send_byte(8'h10);
      send_frame(8'h99, 1'b0);
      send_byte(8'h22);
      send_pair(8'h20, 8'h25);
      check("pin_or_after_malformed", last_res, 8'h66);

      // Reset while TX is mid-frame and RX is mid-frame.
      send_pair(8'h20, 8'h26);
      check("pin_xor", last_res, 8'h66);
      fork
         send_frame(8'hF8, 1'b1);
      join_none
      wait_clks(BIT * 9 / 2);
      do_reset();
      wait fork;
      wait_clks(BIT);
      send_pair(8'h08, 8'h05);
      send_pair(8'h20, 8'h20);
      check("pin_b_cleared", last_res, 8'h05);
      send_pair(8'h08, 8'h03);
      send_pair(8'h10, 8'h04);
      send_pair(8'h20, 8'h20);
      check("pin_post_reset_add", last_res, 8'h07);
      send_pair(8'h20, 8'h27);
      check("pin_nor", last_res, 8'hF8);

      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 3))
            0: t = 8'h08;
            1: t = 8'h10;
            2: t = 8'h20;
            default: t = 8'($urandom_range(0, 255));
         endcase
         if (t == 8'h20 && $urandom_range(0, 1) == 1)
            v = ops[$urandom_range(0, 7)];
         else
            v = 8'($urandom_range(0, 255));
         send_pair(t, v);
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 30 * BIT) begin
         wait_clks(1);
         guard++;
      end
      check("tx_drain_outstanding", 8'(exp_q.size()), 8'h00);
      wait_clks(2 * BIT);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
